// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bi subtractor, LSB first, one bit per clock, valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the signed-overflow output OV.
module serial_subtractor #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bi,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] D,
    output logic         Bo,
    output logic         out_valid,
    input  logic         out_ready
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic         OV
`endif
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_d;
    logic          r_bor;
    logic [CW-1:0] r_cnt;
    logic          w_accept;
    logic          w_last;
    logic          w_dbit;
    logic          w_bnext;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_cnt == CW'(W - 1));
    assign w_dbit   = r_a[0] ^ r_b[0] ^ r_bor;
    assign w_bnext  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bor);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand registers shift right so the current bit is always at index 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_d   <= '0;
            r_bor <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_d   <= '0;
            r_bor <= Bi;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a        <= r_a >> 1;
            r_b        <= r_b >> 1;
            r_bor      <= w_bnext;
            r_d[r_cnt] <= w_dbit;
            r_cnt      <= r_cnt + CW'(1);
        end
    end

    // Result registers are left intact after hand-off; the outputs are masked in IDLE.
    assign D  = (r_state == IDLE) ? '0 : r_d;
    assign Bo = (r_state == IDLE) ? 1'b0 : r_bor;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic r_amsb;
    logic r_bmsb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
        end else if (w_accept) begin
            r_amsb <= A[W-1];
            r_bmsb <= B[W-1];
        end
    end

    assign OV = out_valid && (r_amsb != r_bmsb) && (r_d[W-1] != r_amsb);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed W=4 checks, then random W=8 traffic against an arithmetic model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // W=4 instance
    logic       rst4, bi4, iv4, or4, ird4, ovld4, bo4;
    logic [3:0] a4, b4, d4;
    // W=8 instance
    logic       rst8, bi8, iv8, or8, ird8, ovld8, bo8;
    logic [7:0] a8, b8, d8;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic       ov4, ov8;
`endif

    serial_subtractor #(.W(4)) u_dut4 (
        .clk(clk), .reset(rst4), .A(a4), .B(b4), .Bi(bi4), .in_valid(iv4),
        .in_ready(ird4), .D(d4), .Bo(bo4), .out_valid(ovld4), .out_ready(or4)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        , .OV(ov4)
`endif
    );

    serial_subtractor #(.W(8)) u_dut8 (
        .clk(clk), .reset(rst8), .A(a8), .B(b8), .Bi(bi8), .in_valid(iv8),
        .in_ready(ird8), .D(d8), .Bo(bo8), .out_valid(ovld8), .out_ready(or8)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        , .OV(ov8)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ov, bo, d} from plain integer arithmetic on the operand values.
    function automatic logic [9:0] model(input int w, input int a, input int b, input int bi);
        int   diff, sa, sb, sd;
        logic ov;
        diff = a - b - bi;
        sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        sd   = sa - sb - bi;
        ov   = (sd > (1 << (w - 1)) - 1) || (sd < -(1 << (w - 1)));
        model = {ov, (diff < 0), 8'(diff & ((1 << w) - 1))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input int a, input int b, input int bi, input bit hold);
        logic [9:0] e;
        logic [3:0] dsav;
        logic       bsav;
        e   = model(4, a, b, bi);
        a4  = 4'(a); b4 = 4'(b); bi4 = 1'(bi); iv4 = 1'b1; or4 = 1'b0;
        tick();
        iv4 = 1'b0; a4 = ~a4; b4 = 4'($urandom); bi4 = ~bi4;
        chk("acc_in_ready", ird4, 0);
        chk("run_ovld0", ovld4, 0);
        repeat (3) begin
            tick();
            chk("run_ovld", ovld4, 0);
        end
        tick();
        chk("done_ovld", ovld4, 1);
        chk("done_D", d4, e[3:0]);
        chk("done_Bo", bo4, e[8]);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk("done_OV", ov4, e[9]);
`endif
        if (hold) begin
            dsav = d4; bsav = bo4;
            repeat (5) begin
                a4 = 4'($urandom); b4 = 4'($urandom); iv4 = 1'($urandom);
                tick();
                chk("hold_D", d4, dsav);
                chk("hold_Bo", bo4, bsav);
                chk("hold_ird", ird4, 0);
                chk("hold_ovld", ovld4, 1);
            end
            iv4 = 1'b1;  // offered in the hand-off cycle, must be ignored
        end
        or4 = 1'b1;
        tick();
        or4 = 1'b0; iv4 = 1'b0;
        chk("ret_ird", ird4, 1);
        chk("ret_ovld", ovld4, 0);
        chk("idle_D", d4, 0);
        chk("idle_Bo", bo4, 0);
    endtask

    initial begin
        logic [9:0] q[$];
        logic [9:0] e;
        int pushed, popped, cyc;

        rst4 = 1'b1; rst8 = 1'b1;
        a4 = '0; b4 = '0; bi4 = 0; iv4 = 0; or4 = 0;
        a8 = '0; b8 = '0; bi8 = 0; iv8 = 0; or8 = 0;
        #2;
        chk("rst_D", d4, 0);
        chk("rst_Bo", bo4, 0);
        chk("rst_ovld", ovld4, 0);
        chk("rst_ird", ird4, 1);
        chk("rst8_ird", ird8, 1);
        chk("rst8_ovld", ovld8, 0);
        #1;
        rst4 = 1'b0; rst8 = 1'b0;

        run4(9, 3, 0, 0);
        run4(3, 5, 0, 0);
        run4(0, 0, 1, 0);
        run4(6, 6, 0, 0);
        run4(7, 15, 0, 0);
        run4(5, 2, 0, 1);

        // Reset in the second RUN cycle discards the operation.
        a4 = 4'd9; b4 = 4'd3; bi4 = 0; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        tick();
        rst4 = 1'b1;
        #1;
        chk("mid_rst_D", d4, 0);
        chk("mid_rst_Bo", bo4, 0);
        chk("mid_rst_ird", ird4, 1);
        chk("mid_rst_ovld", ovld4, 0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk("mid_rst_OV", ov4, 0);
`endif
        #1;
        rst4 = 1'b0;
        repeat (6) begin
            tick();
            chk("post_rst_ovld", ovld4, 0);
        end
        run4(9, 3, 0, 0);

        // Random back-to-back traffic on the W=8 instance.
        pushed = 0; popped = 0; cyc = 0;
        while ((pushed < 40 || q.size() != 0) && cyc < 3000) begin
            iv8 = (pushed < 40) && ($urandom_range(0, 4) != 0);
            a8  = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom_range(0, 1));
            or8 = ($urandom_range(0, 3) != 0);
            if (iv8 && ird8) begin
                q.push_back(model(8, int'(a8), int'(b8), int'(bi8)));
                pushed++;
            end
            if (ovld8 && or8) begin
                if (q.size() == 0) begin
                    chk("r8_dup", 1, 0);
                end else begin
                    e = q.pop_front();
                    popped++;
                    chk("r8_D", d8, e[7:0]);
                    chk("r8_Bo", bo8, e[8]);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    chk("r8_OV", ov8, e[9]);
`endif
                end
            end
            tick();
            cyc++;
        end
        chk("r8_timeout", (cyc < 3000), 1);
        chk("r8_count", popped, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the operand and difference width in bits; legal range is W >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port A, input, W bits: the minuend.
REQ-005 The block SHALL have port B, input, W bits: the subtrahend.
REQ-006 The block SHALL have port Bi, input, 1 bit: borrow-in.
REQ-007 The block SHALL have port in_valid, input, 1 bit: A, B and Bi are valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-009 The block SHALL have port D, output, W bits: the difference A - B - Bi.
REQ-010 The block SHALL have port Bo, output, 1 bit: borrow-out, 1 when A < B + Bi as unsigned values.
REQ-011 The block SHALL have port out_valid, output, 1 bit: D, Bo and OV hold a result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port OV, output, 1 bit: two's-complement signed overflow; present only per REQ-029.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-016 At a rising edge in IDLE with in_valid=1, the block SHALL latch A, B and Bi into internal shift/borrow registers, clear the bit counter to 0 and move to RUN.
REQ-017 Each RUN edge SHALL process one bit, LSB first:
- inputs: a=A[i], b=B[i], borrow r
- d = a^b^r
- r_next = (~a&b) | (~(a^b)&r)
- d is shifted into the difference register at position i; then i increments.
REQ-018 After the W-th RUN edge the block SHALL move to DONE, so out_valid rises exactly W cycles after the acceptance edge.
REQ-019 In DONE, D, Bo and OV SHALL equal the final difference register and final borrow, and SHALL remain stable until the result is accepted.
REQ-020 At a DONE edge with out_ready=1 the block SHALL return to IDLE; with out_ready=0 it SHALL stay in DONE indefinitely.
REQ-021 in_valid SHALL be ignored in RUN and DONE: no new operand is latched, including in the same cycle the result is accepted (minimum issue interval W+2 cycles).
REQ-022 Changes on A, B or Bi after acceptance SHALL NOT affect the in-flight result.
REQ-023 Arithmetic SHALL be modulo 2^W: D = (A - B - Bi) mod 2^W.
REQ-024 Boundary results:
- A=0, B=0, Bi=1 gives D=all ones, Bo=1.
- A=B, Bi=0 gives D=0, Bo=0.
REQ-025 D and Bo SHALL read 0 in IDLE, and SHALL hold partial values in RUN that consumers must ignore while out_valid=0.

Reset
REQ-026 Asserting reset SHALL immediately force:
- state to IDLE and bit counter to 0
- internal registers to 0
- D=0, Bo=0, OV=0, out_valid=0, in_ready=1
REQ-027 Reset asserted mid-RUN or in DONE SHALL discard the operation with no result ever presented.
REQ-028 At the first rising edge after reset deasserts, the block SHALL accept in_valid normally.

Configuration
REQ-029 Macro SERIAL_SUBTRACTOR_OVERFLOW_EN controls the OV port:
- Defined: OV exists and, in DONE, equals (A[W-1] != B[W-1]) && (D[W-1] != A[W-1]) for the latched operands; OV is 0 in IDLE/RUN and on reset.
- Undefined: the OV port and its logic are absent; all other behaviour is unchanged.

Verification
REQ-030 W=4: A=9, B=3, Bi=0 accepted -> out_valid exactly 4 cycles later; D=6, Bo=0.
REQ-031 W=4: A=3, B=5, Bi=0 -> D=14 (1110), Bo=1; A=0, B=0, Bi=1 -> D=15, Bo=1.
REQ-032 W=4: out_ready held 0 for 5 cycles in DONE while A, B and in_valid toggle -> D/Bo stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-033 W=4: reset pulsed during the 2nd RUN cycle -> outputs 0 and in_ready=1 immediately; a fresh operation A=9, B=3 then yields D=6.
REQ-034 W=4 with SERIAL_SUBTRACTOR_OVERFLOW_EN:
- A=7, B=15, Bi=0 -> D=8, Bo=1, OV=1.
- A=5, B=2 -> D=3, OV=0.
REQ-035 W=8, random back-to-back operands with random out_ready -> every result matches the modulo-256 reference; no result is dropped or duplicated.
